cpu_jtag_ocimem_monitor: RTL and testbench

//  Consumes JTAG debug-module memory commands (take_action_ocimem_a/b, take_no_action_ocimem_a, jdo)
//  in the clk domain and executes them against the on-chip debug RAM (OCI memory).

---
 rtl/cpu_jtag_ocimem_pkg.sv | 14 +
 rtl/cpu_ocimem_ram.sv | 23 ++
 rtl/cpu_jtag_ocimem_monitor.sv | 163 ++++++++++++++++
 tb/tb_cpu_jtag_ocimem_monitor.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_jtag_ocimem_pkg.sv
// Shared types and jdo field positions for the JTAG OCI memory monitor.
package cpu_jtag_ocimem_pkg;
  localparam int JDO_W        = 38;
  localparam int DATA_W       = 32;
  localparam int JDO_RDEN     = 33;
  localparam int JDO_DATA_MSB = 32;
  localparam int JDO_DATA_LSB = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    JRD  = 2'd1,
    CRD  = 2'd2
  } state_e;
endpackage

// File: rtl/cpu_ocimem_ram.sv
// Single-port DEPTH x 32 debug RAM with a registered read and write-first behaviour.
module cpu_ocimem_ram #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  output logic [31:0]       rdata_o
);
  logic [31:0] mem_q [DEPTH];

  // Callers only assert we_i for in-range addresses.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
      rdata_o       <= wdata_i;
    end else begin
      rdata_o <= mem_q[addr_i];
    end
  end
endmodule

// File: rtl/cpu_jtag_ocimem_monitor.sv
// Executes JTAG debug memory commands against the OCI RAM and shares it with a CPU Avalon-MM slave.
module cpu_jtag_ocimem_monitor
  import cpu_jtag_ocimem_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  input  logic [JDO_W-1:0]  jdo,
  input  logic [ADDR_W-1:0] avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  output logic [31:0]       avs_readdata,
  output logic              avs_waitrequest,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error,
  output logic [1:0]        dbg_state_o,
  output logic [ADDR_W-1:0] dbg_mon_areg_o
);
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] mon_areg_q, mon_areg_d, rd_addr_q, rd_addr_d;
  logic [31:0]       mon_dreg_q, mon_dreg_d;
  logic              ready_q, ready_d, error_q, error_d;
  logic              jrd_phase_q, jrd_phase_d, rd_oor_q, rd_oor_d, crd_oor_q, crd_oor_d;
  logic              jtag_pulse, ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wdata, ram_q;
  logic              unused_jdo;

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return (int'(a) < DEPTH);
  endfunction

  assign jtag_pulse = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
  assign unused_jdo = ^{jdo[JDO_W-1:JDO_RDEN+1], jdo[0]};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      mon_areg_q  <= '0;
      rd_addr_q   <= '0;
      mon_dreg_q  <= '0;
      ready_q     <= 1'b1;
      error_q     <= 1'b0;
      jrd_phase_q <= 1'b0;
      rd_oor_q    <= 1'b0;
      crd_oor_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      mon_areg_q  <= mon_areg_d;
      rd_addr_q   <= rd_addr_d;
      mon_dreg_q  <= mon_dreg_d;
      ready_q     <= ready_d;
      error_q     <= error_d;
      jrd_phase_q <= jrd_phase_d;
      rd_oor_q    <= rd_oor_d;
      crd_oor_q   <= crd_oor_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    mon_areg_d  = mon_areg_q;
    rd_addr_d   = rd_addr_q;
    mon_dreg_d  = mon_dreg_q;
    ready_d     = ready_q;
    error_d     = error_q;
    jrd_phase_d = jrd_phase_q;
    rd_oor_d    = rd_oor_q;
    crd_oor_d   = crd_oor_q;
    case (state_q)
      IDLE: begin
        ready_d     = 1'b1;
        jrd_phase_d = 1'b0;
        if (take_action_ocimem_a) begin
          mon_areg_d = jdo[ADDR_W:1];
          error_d    = 1'b0;
          // A JTAG read always post-increments, so a following read-next fetches the next word.
          if (jdo[JDO_RDEN]) begin
            mon_areg_d = jdo[ADDR_W:1] + 1'b1;
            rd_addr_d  = jdo[ADDR_W:1];
            rd_oor_d   = !in_range(jdo[ADDR_W:1]);
            ready_d    = 1'b0;
            state_d    = JRD;
          end
        end else if (take_action_ocimem_b) begin
          mon_areg_d = mon_areg_q + 1'b1;
          ready_d    = 1'b0;
          if (!in_range(mon_areg_q)) error_d = 1'b1;
        end else if (take_no_action_ocimem_a) begin
          mon_areg_d = mon_areg_q + 1'b1;
          rd_addr_d  = mon_areg_q;
          rd_oor_d   = !in_range(mon_areg_q);
          ready_d    = 1'b0;
          state_d    = JRD;
        end else if (avs_read) begin
          crd_oor_d = !in_range(avs_address);
          state_d   = CRD;
        end
      end
      JRD: begin
        if (jtag_pulse) error_d = 1'b1;
        if (!jrd_phase_q) begin
          jrd_phase_d = 1'b1;
        end else begin
          mon_dreg_d  = rd_oor_q ? '0 : ram_q;
          if (rd_oor_q) error_d = 1'b1;
          ready_d     = 1'b1;
          jrd_phase_d = 1'b0;
          state_d     = IDLE;
        end
      end
      CRD: begin
        if (jtag_pulse) error_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // RAM port steering: JRD owns it for the pending read, otherwise JTAG writes beat the CPU.
  always_comb begin
    ram_addr     = avs_address;
    ram_wdata    = avs_writedata;
    ram_we       = 1'b0;
    avs_readdata = '0;
    if (state_q == JRD) begin
      ram_addr = rd_addr_q;
    end else if (state_q == IDLE) begin
      if (take_action_ocimem_b) begin
        ram_addr  = mon_areg_q;
        ram_wdata = jdo[JDO_DATA_MSB:JDO_DATA_LSB];
        ram_we    = reset_n && in_range(mon_areg_q);
      end else if (!jtag_pulse && avs_write) begin
        ram_we = reset_n && in_range(avs_address);
      end
    end
    if (state_q == CRD && !crd_oor_q) avs_readdata = ram_q;
    avs_waitrequest = (avs_read || avs_write)
                      && !(state_q == IDLE && avs_write && !jtag_pulse)
                      && !(state_q == CRD);
  end

  cpu_ocimem_ram #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .addr_i  (ram_addr),
    .wdata_i (ram_wdata),
    .rdata_o (ram_q)
  );

  assign MonDReg        = mon_dreg_q;
  assign monitor_ready  = ready_q;
  assign monitor_error  = error_q;
  assign dbg_state_o    = state_q;
  assign dbg_mon_areg_o = mon_areg_q;
endmodule

// File: tb/tb_cpu_jtag_ocimem_monitor.sv
// Directed bench: a full-depth instance and a 200-word instance driven by the same stimulus.
module tb_cpu_jtag_ocimem_monitor;
  import cpu_jtag_ocimem_pkg::*;

  localparam logic [1:0] K_A = 2'd0;
  localparam logic [1:0] K_B = 2'd1;
  localparam logic [1:0] K_N = 2'd2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        pa = 1'b0, pb = 1'b0, pn = 1'b0;
  logic [37:0] jdo = '0;
  logic [7:0]  avs_address = '0;
  logic        avs_read = 1'b0, avs_write = 1'b0;
  logic [31:0] avs_writedata = '0;

  logic [31:0] rdata0, dreg0, rdata1, dreg1;
  logic        wait0, ready0, err0, wait1, ready1, err1;
  logic [1:0]  st0, st1;
  logic [7:0]  areg0, areg1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cpu_jtag_ocimem_monitor #(.ADDR_W(8), .DEPTH(256)) u0 (
    .clk(clk), .reset_n(reset_n),
    .take_action_ocimem_a(pa), .take_action_ocimem_b(pb), .take_no_action_ocimem_a(pn),
    .jdo(jdo), .avs_address(avs_address), .avs_read(avs_read), .avs_write(avs_write),
    .avs_writedata(avs_writedata), .avs_readdata(rdata0), .avs_waitrequest(wait0),
    .MonDReg(dreg0), .monitor_ready(ready0), .monitor_error(err0),
    .dbg_state_o(st0), .dbg_mon_areg_o(areg0)
  );

  cpu_jtag_ocimem_monitor #(.ADDR_W(8), .DEPTH(200)) u1 (
    .clk(clk), .reset_n(reset_n),
    .take_action_ocimem_a(pa), .take_action_ocimem_b(pb), .take_no_action_ocimem_a(pn),
    .jdo(jdo), .avs_address(avs_address), .avs_read(avs_read), .avs_write(avs_write),
    .avs_writedata(avs_writedata), .avs_readdata(rdata1), .avs_waitrequest(wait1),
    .MonDReg(dreg1), .monitor_ready(ready1), .monitor_error(err1),
    .dbg_state_o(st1), .dbg_mon_areg_o(areg1)
  );

  typedef struct {
    logic [1:0]  kind;
    logic [7:0]  addr;
    logic        rden;
    logic [31:0] data;
    logic [31:0] exp_dreg;
    logic        exp_err;
    logic [7:0]  exp_areg;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge following the sampling edge.
  task automatic send(input logic [1:0] kind, input logic [7:0] addr, input logic rden,
                      input logic [31:0] data);
    jdo = '0;
    if (kind == K_A) begin
      jdo[8:1] = addr;
      jdo[33]  = rden;
      pa = 1'b1;
    end else if (kind == K_B) begin
      jdo[32:1] = data;
      pb = 1'b1;
    end else begin
      pn = 1'b1;
    end
    @(negedge clk);
    pa = 1'b0; pb = 1'b0; pn = 1'b0;
    jdo = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0]  = '{K_A, 8'd5,   1'b0, 32'h0,        32'h0,        1'b0, 8'd5};
    vecs[1]  = '{K_B, 8'd0,   1'b0, 32'hDEADBEEF, 32'h0,        1'b0, 8'd6};
    vecs[2]  = '{K_B, 8'd0,   1'b0, 32'h12345678, 32'h0,        1'b0, 8'd7};
    vecs[3]  = '{K_A, 8'd5,   1'b1, 32'h0,        32'hDEADBEEF, 1'b0, 8'd6};
    vecs[4]  = '{K_N, 8'd0,   1'b0, 32'h0,        32'h12345678, 1'b0, 8'd7};
    vecs[5]  = '{K_A, 8'd255, 1'b0, 32'h0,        32'h12345678, 1'b0, 8'd255};
    vecs[6]  = '{K_B, 8'd0,   1'b0, 32'hA5A50001, 32'h12345678, 1'b0, 8'd0};
    vecs[7]  = '{K_A, 8'd255, 1'b1, 32'h0,        32'hA5A50001, 1'b0, 8'd0};
    vecs[8]  = '{K_A, 8'd0,   1'b0, 32'h0,        32'hA5A50001, 1'b0, 8'd0};
    vecs[9]  = '{K_B, 8'd0,   1'b0, 32'h0BADF00D, 32'hA5A50001, 1'b0, 8'd1};
    vecs[10] = '{K_A, 8'd0,   1'b1, 32'h0,        32'h0BADF00D, 1'b0, 8'd1};

    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("rst_ready", 32'(ready0), 32'd1);
    check("rst_error", 32'(err0), 32'd0);
    check("rst_dreg", dreg0, 32'h0);
    check("rst_areg", 32'(areg0), 32'd0);
    check("rst_state", 32'(st0), 32'(IDLE));
    check("rst_readdata", rdata0, 32'h0);

    foreach (vecs[i]) begin
      send(vecs[i].kind, vecs[i].addr, vecs[i].rden, vecs[i].data);
      repeat (2) @(negedge clk);
      check($sformatf("vec%0d_dreg", i), dreg0, vecs[i].exp_dreg);
      check($sformatf("vec%0d_err", i), 32'(err0), 32'(vecs[i].exp_err));
      check($sformatf("vec%0d_areg", i), 32'(areg0), 32'(vecs[i].exp_areg));
      check($sformatf("vec%0d_ready", i), 32'(ready1 & ready0), 32'd1);
    end
    check("small_dreg_after_vecs", dreg1, 32'h0BADF00D);
    check("small_err_after_vecs", 32'(err1), 32'd0);

    // Write holds ready low for exactly one cycle.
    send(K_B, 8'd0, 1'b0, 32'h11111111);
    check("wr_ready_low", 32'(ready0), 32'd0);
    @(negedge clk);
    check("wr_ready_back", 32'(ready0), 32'd1);
    check("wr_areg", 32'(areg0), 32'd2);

    // Read timing: ready low after E0 and E1, back with data after E2.
    send(K_A, 8'd1, 1'b1, 32'h0);
    check("rd_e0_ready", 32'(ready0), 32'd0);
    check("rd_e0_state", 32'(st0), 32'(JRD));
    @(negedge clk);
    check("rd_e1_ready", 32'(ready0), 32'd0);
    @(negedge clk);
    check("rd_e2_ready", 32'(ready0), 32'd1);
    check("rd_e2_state", 32'(st0), 32'(IDLE));
    check("rd_e2_dreg", dreg0, 32'h11111111);

    // Out-of-range read and write on the 200-word instance.
    send(K_A, 8'd210, 1'b1, 32'h0);
    repeat (2) @(negedge clk);
    check("oor_rd_dreg", dreg1, 32'h0);
    check("oor_rd_err", 32'(err1), 32'd1);
    check("oor_rd_err_full", 32'(err0), 32'd0);
    send(K_A, 8'd0, 1'b0, 32'h0);
    check("oor_err_clear", 32'(err1), 32'd0);
    send(K_A, 8'd250, 1'b0, 32'h0);
    send(K_B, 8'd0, 1'b0, 32'h77777777);
    check("oor_wr_err", 32'(err1), 32'd1);
    check("oor_wr_areg", 32'(areg1), 32'd251);
    check("oor_wr_err_full", 32'(err0), 32'd0);
    send(K_A, 8'd0, 1'b0, 32'h0);
    repeat (2) @(negedge clk);

    // Read-next one cycle after a read pulse is ignored and flags an error.
    send(K_A, 8'd5, 1'b1, 32'h0);
    send(K_N, 8'd0, 1'b0, 32'h0);
    @(negedge clk);
    check("busy_err", 32'(err0), 32'd1);
    check("busy_dreg", dreg0, 32'hDEADBEEF);
    check("busy_areg", 32'(areg0), 32'd6);
    check("busy_ready", 32'(ready0), 32'd1);
    send(K_A, 8'd0, 1'b0, 32'h0);
    repeat (2) @(negedge clk);

    // CPU read colliding with a JTAG read: JTAG first, then the CPU completes.
    avs_address = 8'd6;
    avs_read    = 1'b1;
    jdo         = '0;
    jdo[8:1]    = 8'd5;
    jdo[33]     = 1'b1;
    pa          = 1'b1;
    #1;
    check("col_wait_p", 32'(wait0), 32'd1);
    @(negedge clk);
    pa = 1'b0;
    jdo = '0;
    #1;
    check("col_wait_e0", 32'(wait0), 32'd1);
    @(negedge clk);
    check("col_wait_e1", 32'(wait0), 32'd1);
    @(negedge clk);
    check("col_wait_idle", 32'(wait0), 32'd1);
    check("col_state_idle", 32'(st0), 32'(IDLE));
    check("col_jtag_dreg", dreg0, 32'hDEADBEEF);
    @(negedge clk);
    check("col_state_crd", 32'(st0), 32'(CRD));
    check("col_wait_crd", 32'(wait0), 32'd0);
    check("col_readdata", rdata0, 32'h12345678);
    avs_read = 1'b0;
    @(negedge clk);
    check("col_back_idle", 32'(st0), 32'(IDLE));

    // CPU write completes immediately; CPU read takes two cycles; JTAG sees the data.
    avs_address   = 8'd20;
    avs_writedata = 32'hCAFE0020;
    avs_write     = 1'b1;
    #1;
    check("cpu_wr_wait", 32'(wait0), 32'd0);
    @(negedge clk);
    avs_write = 1'b0;
    avs_read  = 1'b1;
    #1;
    check("cpu_rd_wait_idle", 32'(wait0), 32'd1);
    @(negedge clk);
    check("cpu_rd_wait_crd", 32'(wait0), 32'd0);
    check("cpu_rd_data", rdata0, 32'hCAFE0020);
    avs_read = 1'b0;
    @(negedge clk);
    send(K_A, 8'd20, 1'b1, 32'h0);
    repeat (2) @(negedge clk);
    check("jtag_sees_cpu_wr", dreg0, 32'hCAFE0020);
    avs_address = 8'd210;
    avs_read    = 1'b1;
    @(negedge clk);
    check("cpu_oor_wait", 32'(wait1), 32'd0);
    check("cpu_oor_data", rdata1, 32'h0);
    avs_read = 1'b0;
    @(negedge clk);

    // Reset in the middle of a JTAG read.
    send(K_A, 8'd5, 1'b1, 32'h0);
    check("mid_state_jrd", 32'(st0), 32'(JRD));
    reset_n = 1'b0;
    #1;
    check("mid_rst_ready", 32'(ready0), 32'd1);
    check("mid_rst_dreg", dreg0, 32'h0);
    check("mid_rst_areg", 32'(areg0), 32'd0);
    check("mid_rst_state", 32'(st0), 32'(IDLE));
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    send(K_A, 8'd5, 1'b1, 32'h0);
    repeat (2) @(negedge clk);
    check("ram_retained", dreg0, 32'hDEADBEEF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
